line_fill_icache: RTL and testbench

// Read-only direct-mapped instruction cache sitting between the core fetch port and the
// 256-bit line-granular main memory model. Serves 32-bit word reads from cpu side; on miss

---
 rtl/line_fill_icache.sv | 133 +++++++++++++
 tb/tb_line_fill_icache.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/line_fill_icache.sv
// Direct-mapped read-only I-cache: 32-bit cpu word reads, 256-bit line fills.
// Ports: clk/rst_n, cpu_* fetch side, pmem_* line side, CACHE_STATS_EN adds hit/miss_count.
module line_fill_icache #(
  parameter int NUM_SETS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  cpu_addr,
  input  logic         cpu_read,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 27 - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    FILL
  } state_e;

  state_e              state_q, state_d;
  logic [31:2]         addr_q, addr_d;
  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [255:0]        data_q [NUM_SETS];

  logic [2:0]          word;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                fill_we;
  logic                unused_addr;

  assign unused_addr = ^cpu_addr[1:0];

  assign word    = addr_q[4:2];
  assign idx     = addr_q[4+IDX_W:5];
  assign tag     = addr_q[31:5+IDX_W];
  assign hit     = (state_q == LOOKUP) && valid_q[idx]
                   && (tag_q[idx] == tag);
  assign fill_we = (state_q == FILL) && pmem_resp;

  assign cpu_resp     = hit;
  assign cpu_rdata    = hit ? data_q[idx][{word, 5'b00000} +: 32] : '0;
  assign pmem_read    = (state_q == FILL);
  assign pmem_address = pmem_read ? {tag, idx, 5'b00000} : '0;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (cpu_read) begin
          addr_d  = cpu_addr[31:2];
          state_d = LOOKUP;
        end
      end
      LOOKUP: state_d = hit ? IDLE : FILL;
      FILL: begin
        if (pmem_resp) begin
          valid_d[idx] = 1'b1;
          state_d      = LOOKUP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
    end
  end

  // Arrays carry no reset; valid_q alone gates their contents.
  always_ff @(posedge clk) begin
    if (rst_n && fill_we) begin
      data_q[idx] <= pmem_rdata;
      tag_q[idx]  <= tag;
    end
  end

`ifdef CACHE_STATS_EN
  logic        refill_q, refill_d;
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;

  // refill marks the replay lookup so it is not counted as a hit.
  always_comb begin
    refill_d = refill_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    if (state_q == IDLE && cpu_read) refill_d = 1'b0;
    if (fill_we) refill_d = 1'b1;
    if (hit && !refill_q) hit_d = hit_q + 32'd1;
    if (state_q == LOOKUP && !hit) miss_d = miss_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refill_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      refill_q <= refill_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_line_fill_icache.sv
// Directed bench for line_fill_icache with a queued scoreboard
// and a line memory model whose response delay is programmable.
module tb_line_fill_icache;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  cpu_addr = '0;
  logic         cpu_read = 1'b0;
  logic [31:0]  cpu_rdata;
  logic         cpu_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int ntests = 0;
  int nfail  = 0;
  int mem_wait = 0;
  int wcnt = 0;
  int rd_cycles = 0;
  logic [31:0] exp_q[$];
  logic [31:0] fill_q[$];

  always #5 clk = ~clk;

  line_fill_icache #(.NUM_SETS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_addr     (cpu_addr),
    .cpu_read     (cpu_read),
    .cpu_rdata    (cpu_rdata),
    .cpu_resp     (cpu_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
`ifdef CACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // Memory model: word at byte address A holds A.
  assign pmem_resp = pmem_read && (wcnt >= mem_wait);

  always_comb begin
    pmem_rdata = 'x;
    if (pmem_resp)
      for (int i = 0; i < 8; i++)
        pmem_rdata[32*i +: 32] = pmem_address + 32'(4 * i);
  end

  always @(posedge clk) begin
    if (pmem_read && !pmem_resp) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  always @(negedge clk) begin
    if (pmem_read) rd_cycles <= rd_cycles + 1;
    if (pmem_read && pmem_resp) fill_q.push_back(pmem_address);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cpu_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // exp_fill < 0 means no line fill expected.
  task automatic do_read(input string tag, input logic [31:0] addr,
                         input int exp_lat, input longint exp_fill,
                         input bit toggle);
    int lat;
    int rd0;
    bit got;
    logic [31:0] exp;
    fill_q.delete();
    exp_q.push_back(addr & 32'hFFFF_FFFC);
    @(negedge clk);
    cpu_addr = addr;
    cpu_read = 1'b1;
    rd0 = rd_cycles;
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 60) begin
      @(negedge clk);
      lat++;
      if (toggle && lat == 2) cpu_addr = addr ^ 32'h0000_0F0C;
      if (cpu_resp) got = 1'b1;
    end
    if (!got) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      chk({tag, "_data"}, cpu_rdata, exp);
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    end
    cpu_read = 1'b0;
    if (exp_fill < 0) begin
      chk({tag, "_nofill"}, 32'(fill_q.size()), 32'd0);
    end else begin
      chk({tag, "_nfill"}, 32'(fill_q.size()), 32'd1);
      if (fill_q.size() != 0)
        chk({tag, "_faddr"}, fill_q.pop_front(), exp_fill[31:0]);
      chk({tag, "_rdcyc"}, 32'(rd_cycles - rd0), 32'(mem_wait + 1));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_resp", {31'd0, cpu_resp}, 32'd0);
    chk("rst_pread", {31'd0, pmem_read}, 32'd0);
    chk("rst_paddr", pmem_address, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
`ifdef CACHE_STATS_EN
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
`endif
    rst_n = 1'b1;

    do_read("miss4", 32'h0000_0004, 3, 32'h0000_0000, 1'b0);
    do_read("hit4", 32'h0000_0004, 1, -1, 1'b0);
    do_read("hit1c", 32'h0000_001C, 1, -1, 1'b0);
    do_read("hit0", 32'h0000_0000, 1, -1, 1'b0);

    do_reset();
    do_read("c10a", 32'h0000_0010, 3, 32'h0000_0000, 1'b0);
    do_read("c210", 32'h0000_0210, 3, 32'h0000_0200, 1'b0);
    do_read("c10b", 32'h0000_0010, 3, 32'h0000_0000, 1'b0);

    mem_wait = 5;
    do_read("slow", 32'h0000_03C4, 8, 32'h0000_03C0, 1'b1);
    mem_wait = 0;
    do_read("slowhit", 32'h0000_03D8, 1, -1, 1'b0);

    // Abort a long fill with reset, then the line must refill.
    mem_wait = 10;
    @(negedge clk);
    cpu_addr = 32'h0000_0040;
    cpu_read = 1'b1;
    @(posedge clk);
    repeat (3) @(negedge clk);
    chk("mid_pread", {31'd0, pmem_read}, 32'd1);
    chk("mid_paddr", pmem_address, 32'h0000_0040);
    rst_n = 1'b0;
    cpu_read = 1'b0;
    @(negedge clk);
    chk("abort_pread", {31'd0, pmem_read}, 32'd0);
    chk("abort_paddr", pmem_address, 32'd0);
    chk("abort_resp", {31'd0, cpu_resp}, 32'd0);
    rst_n = 1'b1;
    mem_wait = 0;
    do_read("refill", 32'h0000_0048, 3, 32'h0000_0040, 1'b0);

    do_reset();
    do_read("s_m1", 32'h0000_0080, 3, 32'h0000_0080, 1'b0);
    do_read("s_h1", 32'h0000_0084, 1, -1, 1'b0);
    do_read("s_h2", 32'h0000_0088, 1, -1, 1'b0);
    do_read("s_m2", 32'h0000_0280, 3, 32'h0000_0280, 1'b0);
`ifdef CACHE_STATS_EN
    @(negedge clk);
    chk("stat_hits", hit_count, 32'd2);
    chk("stat_miss", miss_count, 32'd2);
`endif

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
